// File: rtl/frame_cfg_pkg.sv
// Shared constants and types for the frame configuration writer.
package frame_cfg_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hFA;

  // Header word field positions and widths
  localparam int unsigned HDR_SYNC_LSB = 24;
  localparam int unsigned HDR_SYNC_W   = 8;
  localparam int unsigned HDR_COL_LSB  = 8;
  localparam int unsigned HDR_COL_W    = 8;
  localparam int unsigned HDR_FRM_LSB  = 0;
  localparam int unsigned HDR_FRM_W    = 5;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STROBE,
    HOLD
  } state_t;

endpackage

// File: rtl/frame_strobe_decoder.sv
// Registered one-hot decoder: turns a column/frame index pair into a single
// FrameStrobe bit for one cycle per enable pulse.
module frame_strobe_decoder
  import frame_cfg_pkg::*;
#(
  parameter int unsigned MaxFramesPerCol = 20,
  parameter int unsigned NumCols         = 4
) (
  input  logic                                CLK,
  input  logic                                resetn,
  input  logic [HDR_COL_W-1:0]                col,
  input  logic [HDR_FRM_W-1:0]                frm,
  input  logic                                en,
  output logic [NumCols*MaxFramesPerCol-1:0]  strobe
);

  logic [NumCols*MaxFramesPerCol-1:0] onehot;

  // Decode the index pair; all zero unless enabled
  always_comb begin
    onehot = '0;
    for (int unsigned c = 0; c < NumCols; c++) begin
      for (int unsigned f = 0; f < MaxFramesPerCol; f++) begin
        if (en && (col == HDR_COL_W'(c)) && (frm == HDR_FRM_W'(f))) begin
          onehot[c*MaxFramesPerCol + f] = 1'b1;
        end
      end
    end
  end

  // Register the decoded strobe so it is glitch-free at the fabric
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      strobe <= '0;
    end else begin
      strobe <= onehot;
    end
  end

endmodule

// File: rtl/frame_config_writer.sv
// Frame configuration writer: takes header + NumRows data words from a
// valid/ready stream, loads them onto the row FrameData buses and fires a
// one-cycle FrameStrobe at the addressed column/frame.
module frame_config_writer
  import frame_cfg_pkg::*;
#(
  parameter int unsigned FrameBitsPerRow = 32,
  parameter int unsigned MaxFramesPerCol = 20,
  parameter int unsigned NumRows         = 4,
  parameter int unsigned NumCols         = 4,
  parameter int unsigned CntWidth        = 16
) (
  input  logic                                CLK,
  input  logic                                resetn,
  input  logic [FrameBitsPerRow-1:0]          s_data,
  input  logic                                s_valid,
  output logic                                s_ready,
  input  logic                                cfg_abort,
  output logic [NumRows*FrameBitsPerRow-1:0]  FrameData,
  output logic [NumCols*MaxFramesPerCol-1:0]  FrameStrobe,
  output logic                                busy,
  output logic                                err_hdr,
  output logic                                err_range,
  output logic [CntWidth-1:0]                 frame_count
);

  localparam int unsigned RowW = (NumRows > 1) ? $clog2(NumRows) : 1;

  state_t                 state, state_nxt;
  logic                   ready_en;
  logic [RowW-1:0]        row_cnt;
  logic [HDR_COL_W-1:0]   col_q;
  logic [HDR_FRM_W-1:0]   frm_q;

  logic [HDR_SYNC_W-1:0]  hdr_sync;
  logic [HDR_COL_W-1:0]   hdr_col;
  logic [HDR_FRM_W-1:0]   hdr_frm;
  logic                   xfer, hdr_bad, hdr_range, last_row, strobe_en;

  assign hdr_sync  = s_data[HDR_SYNC_LSB +: HDR_SYNC_W];
  assign hdr_col   = s_data[HDR_COL_LSB +: HDR_COL_W];
  assign hdr_frm   = s_data[HDR_FRM_LSB +: HDR_FRM_W];
  assign xfer      = s_valid && s_ready;
  assign hdr_bad   = (hdr_sync != SYNC_BYTE);
  assign hdr_range = (32'(hdr_col) >= 32'(NumCols)) ||
                     (32'(hdr_frm) >= 32'(MaxFramesPerCol));
  assign last_row  = (row_cnt == RowW'(NumRows - 1));
  // An abort in STROBE suppresses both the pulse and the count update
  assign strobe_en = (state == STROBE) && !cfg_abort;

  // State register; ready_en keeps s_ready low until the first edge after reset
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      ready_en <= 1'b0;
    end else begin
      state    <= state_nxt;
      ready_en <= 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (xfer && !hdr_bad && !hdr_range) state_nxt = LOAD;
      LOAD: begin
        if (cfg_abort)             state_nxt = IDLE;
        else if (xfer && last_row) state_nxt = STROBE;
      end
      STROBE:  state_nxt = cfg_abort ? IDLE : HOLD;
      HOLD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake and status outputs
  always_comb begin
    s_ready = ready_en && ((state == IDLE) || (state == LOAD));
    busy    = (state != IDLE);
  end

  // Header latch, row loading, error flags and frame counter
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      FrameData   <= '0;
      frame_count <= '0;
      err_hdr     <= 1'b0;
      err_range   <= 1'b0;
      row_cnt     <= '0;
      col_q       <= '0;
      frm_q       <= '0;
    end else begin
      if ((state == IDLE) && xfer) begin
        if (hdr_bad) begin
          err_hdr <= 1'b1;
        end else if (hdr_range) begin
          err_range <= 1'b1;
        end else begin
          col_q   <= hdr_col;
          frm_q   <= hdr_frm;
          row_cnt <= '0;
        end
      end
      if ((state == LOAD) && xfer && !cfg_abort) begin
        FrameData[row_cnt*FrameBitsPerRow +: FrameBitsPerRow] <= s_data;
        row_cnt <= row_cnt + 1'b1;
      end
      if (strobe_en) begin
        frame_count <= frame_count + 1'b1;
      end
    end
  end

  frame_strobe_decoder #(
    .MaxFramesPerCol (MaxFramesPerCol),
    .NumCols         (NumCols)
  ) u_strobe_dec (
    .CLK    (CLK),
    .resetn (resetn),
    .col    (col_q),
    .frm    (frm_q),
    .en     (strobe_en),
    .strobe (FrameStrobe)
  );

endmodule

// File: tb/tb_frame_config_writer.sv
// Scoreboard bench for frame_config_writer. A second instance with a 2-bit
// counter shares the stimulus so counter wrap-around is reached quickly.
module tb_frame_config_writer;

  localparam int unsigned FB = 32;
  localparam int unsigned MF = 20;
  localparam int unsigned NR = 4;
  localparam int unsigned NC = 4;

  logic            CLK = 1'b0;
  logic            resetn;
  logic [FB-1:0]   s_data;
  logic            s_valid;
  logic            cfg_abort;

  logic            s_ready, busy, err_hdr, err_range;
  logic [NR*FB-1:0] FrameData;
  logic [NC*MF-1:0] FrameStrobe;
  logic [15:0]     frame_count;

  logic            s_ready_w, busy_w, err_hdr_w, err_range_w;
  logic [NR*FB-1:0] FrameData_w;
  logic [NC*MF-1:0] FrameStrobe_w;
  logic [1:0]      frame_count_w;

  always #5 CLK = ~CLK;

  frame_config_writer #(
    .FrameBitsPerRow (FB),
    .MaxFramesPerCol (MF),
    .NumRows         (NR),
    .NumCols         (NC),
    .CntWidth        (16)
  ) u_dut (
    .CLK         (CLK),
    .resetn      (resetn),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .cfg_abort   (cfg_abort),
    .FrameData   (FrameData),
    .FrameStrobe (FrameStrobe),
    .busy        (busy),
    .err_hdr     (err_hdr),
    .err_range   (err_range),
    .frame_count (frame_count)
  );

  frame_config_writer #(
    .FrameBitsPerRow (FB),
    .MaxFramesPerCol (MF),
    .NumRows         (NR),
    .NumCols         (NC),
    .CntWidth        (2)
  ) u_wrap (
    .CLK         (CLK),
    .resetn      (resetn),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready_w),
    .cfg_abort   (cfg_abort),
    .FrameData   (FrameData_w),
    .FrameStrobe (FrameStrobe_w),
    .busy        (busy_w),
    .err_hdr     (err_hdr_w),
    .err_range   (err_range_w),
    .frame_count (frame_count_w)
  );

  typedef struct {
    logic [NC*MF-1:0] strobe;
    logic [15:0]      cnt;
    logic [NR*FB-1:0] data;
  } exp_t;

  exp_t             q[$];
  exp_t             mon_e;
  int               errors = 0;
  int               checks = 0;
  logic [NR*FB-1:0] shadow;
  int               exp_count;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: every nonzero strobe cycle must match the next expected frame
  always @(negedge CLK) begin
    if (resetn === 1'b1 && FrameStrobe !== '0) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got %0h expected none", FrameStrobe);
      end else begin
        mon_e = q.pop_front();
        chk("strobe_vec", FrameStrobe, mon_e.strobe);
        chk("strobe_count", frame_count, mon_e.cnt);
        chk("strobe_data", FrameData, mon_e.data);
        chk("wrap_strobe", FrameStrobe_w, mon_e.strobe);
        chk("wrap_count", frame_count_w, mon_e.cnt[1:0]);
      end
    end
  end

  // Offer one word after gap idle cycles; waits = cycles spent with s_ready low
  task automatic send_word(input logic [31:0] d, input int gap, output int waits);
    @(negedge CLK);
    repeat (gap) @(negedge CLK);
    s_data  = d;
    s_valid = 1'b1;
    waits   = 0;
    while (!s_ready && waits < 50) begin
      @(negedge CLK);
      waits++;
    end
    if (!s_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got s_ready=0 expected 1 within 50 cycles");
      s_valid = 1'b0;
    end else begin
      @(posedge CLK);
      #1;
      s_valid = 1'b0;
    end
  endtask

  function automatic logic [31:0] hdr(input logic [7:0] col, input logic [4:0] frm);
    return {8'hFA, 8'h00, col, 3'b000, frm};
  endfunction

  task automatic send_frame(input logic [7:0] col, input logic [4:0] frm,
                            input logic [NR*FB-1:0] data, input bit gaps,
                            output int hdr_waits);
    int   w;
    exp_t e;
    send_word(hdr(col, frm), 0, hdr_waits);
    for (int r = 0; r < NR; r++) begin
      send_word(data[r*FB +: FB], gaps ? int'($urandom_range(0, 3)) : 0, w);
      shadow[r*FB +: FB] = data[r*FB +: FB];
    end
    exp_count++;
    e.strobe = '0;
    e.strobe[int'(col)*MF + int'(frm)] = 1'b1;
    e.cnt  = 16'(exp_count);
    e.data = shadow;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    resetn    = 1'b0;
    s_valid   = 1'b0;
    cfg_abort = 1'b0;
    s_data    = '0;
    shadow    = '0;
    exp_count = 0;

    // Reset state
    #1;
    chk("rst_data", FrameData, 0);
    chk("rst_strobe", FrameStrobe, 0);
    chk("rst_flags", {s_ready, busy, err_hdr, err_range}, 4'b0000);
    chk("rst_count", frame_count, 0);
    idle(2);
    resetn = 1'b1;
    @(negedge CLK);
    chk("ready_after_rst", s_ready, 1);

    // Main frame: col 2, frame 3 -> bit 43
    send_frame(8'd2, 5'd3, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, 1'b0, w);
    idle(3);
    chk("t1_drained", q.size(), 0);
    chk("t1_count", frame_count, 1);
    chk("t1_data", FrameData, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111});
    chk("t1_busy", busy, 0);

    // Bad sync byte
    send_word(32'hAB00_0000, 0, w);
    @(negedge CLK);
    chk("t2_err_hdr", err_hdr, 1);
    chk("t2_ready", {s_ready, busy, err_range}, 3'b100);
    send_frame(8'd0, 5'd0, {32'hD0D0D0D0, 32'hC0C0C0C0, 32'hB0B0B0B0, 32'hA0A0A0A0}, 1'b0, w);
    idle(3);
    chk("t2_count", frame_count, 2);
    chk("t2_err_sticky", err_hdr, 1);

    // Abort after two data words
    send_word(hdr(8'd1, 5'd5), 0, w);
    send_word(32'h5555AAAA, 0, w);
    shadow[0 +: FB] = 32'h5555AAAA;
    send_word(32'h6666BBBB, 0, w);
    shadow[FB +: FB] = 32'h6666BBBB;
    @(negedge CLK);
    cfg_abort = 1'b1;
    @(negedge CLK);
    cfg_abort = 1'b0;
    chk("t3_busy", busy, 0);
    idle(3);
    chk("t3_count", frame_count, 2);
    chk("t3_data", FrameData, shadow);

    // Reset in the middle of LOAD
    send_word(hdr(8'd3, 5'd19), 0, w);
    send_word(32'h77777777, 0, w);
    send_word(32'h88888888, 0, w);
    @(negedge CLK);
    resetn = 1'b0;
    #1;
    shadow    = '0;
    exp_count = 0;
    chk("t4_rst_data", FrameData, 0);
    chk("t4_rst_flags", {s_ready, busy, err_hdr, err_range}, 4'b0000);
    chk("t4_rst_count", frame_count, 0);
    @(negedge CLK);
    resetn = 1'b1;
    @(negedge CLK);
    chk("t4_ready", {s_ready, busy}, 2'b10);

    // Range errors, then following words parsed as headers
    send_word(hdr(8'd4, 5'd0), 0, w);
    @(negedge CLK);
    chk("t5_col_range", {err_range, err_hdr, busy}, 3'b100);
    send_word(hdr(8'd0, 5'd20), 0, w);
    @(negedge CLK);
    chk("t5_frm_busy", busy, 0);
    for (int i = 0; i < 4; i++) send_word(32'h11111111 * (i + 1), 0, w);
    @(negedge CLK);
    chk("t5_err_hdr", {err_hdr, err_range, busy}, 3'b110);
    chk("t5_data_kept", FrameData, 0);
    send_frame(8'd3, 5'd19, {32'h0000000D, 32'h0000000C, 32'h0000000B, 32'h0000000A}, 1'b0, w);
    idle(3);
    chk("t5_count", frame_count, 1);

    // Back-to-back frames with random data gaps
    for (int i = 0; i < 4; i++) begin
      send_frame(8'(i), 5'(i * 5 + 1),
                 {32'(i) << 28 | 32'h0000_0F03, 32'(i) << 28 | 32'h0000_0F02,
                  32'(i) << 28 | 32'h0000_0F01, 32'(i) << 28 | 32'h0000_0F00},
                 1'b1, w);
      if (i > 0) chk("t6_ready_low_cycles", w, 2);
    end
    idle(4);
    chk("t6_drained", q.size(), 0);
    chk("t6_count", frame_count, 5);
    chk("t6_wrap", frame_count_w, 1);
    chk("t6_twin", {s_ready_w, busy_w, err_hdr_w, err_range_w, FrameData_w},
        {s_ready, busy, err_hdr, err_range, FrameData});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
